cpu_boot_ctrl: RTL and testbench

Parametrised boot-and-run sequencer for the von Neumann CPU family. It holds the CPU in reset and streams a program image into unified memory over a valid/ready byte stream. It then releases the CPU and supervises execution until the CPU signals halt or a configurable cycle budget expires. It replaces the fixed "load, run, stop after a set time" sequencing with synthesizable, width- and depth-generic control.

---
 rtl/cpu_boot_pkg.sv | 15 +
 rtl/boot_run_timer.sv | 29 ++
 rtl/cpu_boot_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_boot_pkg.sv
// Shared types for the cpu_boot_ctrl sequencer: FSM state encoding and checksum width.
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRelease,
    StRun,
    StDone
  } boot_state_e;

  // Default checksum width; the checksum is always one memory word wide.
  localparam int unsigned CsumW = 8;

endpackage

// File: rtl/boot_run_timer.sv
// RUN-phase cycle counter; expired flags the last cycle allowed by the budget.
module boot_run_timer #(
  parameter int unsigned CYC_W = 16,
  parameter int unsigned LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic             expired,
  output logic [CYC_W-1:0] count
);

  logic [CYC_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == CYC_W'(LIMIT - 1));
  assign count   = count_q;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot-and-run sequencer: streams an image into memory, releases the CPU, supervises the run.
// Optional image checksum check enabled by defining BOOT_CHECKSUM_EN.
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int unsigned DATA_W    = CsumW,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned RUN_LIMIT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  input  logic              cpu_halt,
`ifdef BOOT_CHECKSUM_EN
  input  logic [DATA_W-1:0] exp_csum,
  output logic              csum_err,
`endif
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count
);

  boot_state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_rst_n_q, done_q, timeout_q;
  logic              start_acc, hs, ptr_full, in_run, expired;
  logic              csum_bad;

  assign ld_ready  = (state_q == StLoad);
  assign busy      = (state_q == StLoad) || (state_q == StRelease) || (state_q == StRun);
  assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));
  assign hs        = ld_valid && ld_ready;
  assign ptr_full  = (ptr_q == {ADDR_W{1'b1}});
  assign in_run    = (state_q == StRun);

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  logic              csum_err_q;

  assign csum_bad = (csum_q != exp_csum);
  assign csum_err = csum_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        csum_q     <= '0;
        csum_err_q <= 1'b0;
      end else begin
        if (hs) csum_q <= csum_q + ld_data;
        if ((state_q == StRelease) && csum_bad) csum_err_q <= 1'b1;
      end
    end
  end
`else
  assign csum_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StLoad;
      StLoad:         if (hs && (ld_last || ptr_full)) state_d = StRelease;
      StRelease:      state_d = csum_bad ? StDone : StRun;
      StRun:          if (cpu_halt || expired) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_rst_n_q <= (state_d == StRun);
      mem_we_q    <= hs;
      if (hs) begin
        mem_addr_q  <= ptr_q;
        mem_wdata_q <= ld_data;
      end
      if (start_acc) begin
        ptr_q     <= '0;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        if (hs) ptr_q <= ptr_q + 1'b1;
        // Halt wins over the budget when both land in the same cycle.
        if (in_run && cpu_halt) done_q <= 1'b1;
        if (in_run && !cpu_halt && expired) timeout_q <= 1'b1;
      end
    end
  end

  boot_run_timer #(
    .CYC_W(CYC_W),
    .LIMIT(RUN_LIMIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_acc),
    .en     (in_run && !cpu_halt && !expired),
    .expired(expired),
    .count  (cycle_count)
  );

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: default instance plus a 4-word-deep instance.
module tb_cpu_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0, cpu_halt = 1'b0;
  logic [7:0]  ld_data = '0;

  logic        ld_ready, mem_we, cpu_rst_n, busy, done, timeout;
  logic [7:0]  mem_addr, mem_wdata;
  logic [15:0] cycle_count;

  logic        ld_ready2, mem_we2, cpu_rst_n2, busy2, done2, timeout2;
  logic [1:0]  mem_addr2;
  logic [7:0]  mem_wdata2;
  logic [15:0] cycle_count2;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] exp_csum = '0;
  logic       csum_err, csum_err2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_boot_ctrl #(.DATA_W(8), .ADDR_W(8), .CYC_W(16), .RUN_LIMIT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .cpu_halt(cpu_halt),
`ifdef BOOT_CHECKSUM_EN
    .exp_csum(exp_csum), .csum_err(csum_err),
`endif
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  cpu_boot_ctrl #(.DATA_W(8), .ADDR_W(2), .CYC_W(16), .RUN_LIMIT(10)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start2), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(1'b0), .ld_ready(ld_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .cpu_rst_n(cpu_rst_n2), .cpu_halt(cpu_halt),
`ifdef BOOT_CHECKSUM_EN
    .exp_csum(exp_csum), .csum_err(csum_err2),
`endif
    .busy(busy2), .done(done2), .timeout(timeout2), .cycle_count(cycle_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE/DONE and load one word marked last; leaves the DUT in RELEASE.
  task automatic load_one(input logic [7:0] d);
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = d; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  logic [7:0] img [4];
  int run_cycles;

  initial begin
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img[3] = 8'hD4;

    // Reset state
    #12;
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cycle_count", cycle_count, 0);
    rst_n = 1'b1;
    step();

    // Four-word image, halt in RUN cycle 5
`ifdef BOOT_CHECKSUM_EN
    exp_csum = 8'hEA;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_ld_ready", ld_ready, 1);
    check("load_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 3);
      step();
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, i);
      check("wr_data", mem_wdata, img[i]);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("release_cpu_rst_n", cpu_rst_n, 0);
    check("release_ld_ready", ld_ready, 0);
    check("release_busy", busy, 1);
    step();
    check("run_cpu_rst_n", cpu_rst_n, 1);
    check("run_we_low", mem_we, 0);
    check("run_addr_hold", mem_addr, 3);
    check("run_data_hold", mem_wdata, 8'hD4);
    check("run_count0", cycle_count, 0);
    repeat (5) step();
    check("run_count5", cycle_count, 5);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_timeout", timeout, 0);
    check("halt_count", cycle_count, 5);
    check("halt_cpu_rst_n", cpu_rst_n, 0);
    check("halt_busy", busy, 0);

    // Never halt: budget of 10 cycles
`ifdef BOOT_CHECKSUM_EN
    exp_csum = 8'h5A;
`endif
    load_one(8'h5A);
    check("restart_done_clr", done, 0);
    run_cycles = 0;
    step();
    while (cpu_rst_n && run_cycles < 50) begin
      run_cycles++;
      step();
    end
    check("to_run_cycles", run_cycles, 10);
    check("to_timeout", timeout, 1);
    check("to_done", done, 0);
    check("to_count", cycle_count, 9);

    // Halt coincides with the last budget cycle
`ifdef BOOT_CHECKSUM_EN
    exp_csum = 8'h33;
`endif
    load_one(8'h33);
    check("restart_to_clr", timeout, 0);
    step();
    repeat (9) step();
    check("lim_count9", cycle_count, 9);
    check("lim_still_run", cpu_rst_n, 1);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check("lim_done", done, 1);
    check("lim_timeout", timeout, 0);

    // Reset mid-RUN
`ifdef BOOT_CHECKSUM_EN
    exp_csum = 8'h77;
`endif
    load_one(8'h77);
    repeat (3) step();
    check("mid_run_pre", cpu_rst_n, 1);
    rst_n = 1'b0;
    #1;
    check("arst_cpu_rst_n", cpu_rst_n, 0);
    check("arst_busy", busy, 0);
    check("arst_count", cycle_count, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    // 4-deep memory, 5 words without last
`ifdef BOOT_CHECKSUM_EN
    exp_csum = 8'd46;
`endif
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 8'(10 + i);
      step();
      check("full_we", mem_we2, 1);
      check("full_addr", mem_addr2, i);
      check("full_data", mem_wdata2, 10 + i);
    end
    ld_data = 8'd99;
    check("full_ready_low", ld_ready2, 0);
    step();
    ld_valid = 1'b0;
    check("full_no_5th", mem_we2, 0);
    check("full_data_hold", mem_wdata2, 13);
    check("full_run", cpu_rst_n2, 1);
    check("big_idle", busy, 0);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: CPU never released
    exp_csum = 8'h04;
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h01;
    step();
    ld_data = 8'h02; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    step();
    check("csum_err", csum_err, 1);
    check("csum_busy", busy, 0);
    run_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_rst_n) run_cycles++;
      step();
    end
    check("csum_no_release", run_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
